// File: rtl/fc2_argmax.sv
// fc2_argmax: final classifier stage. Captures the 16 signed 16-bit outputs of
// the preceding fully connected layer in one beat, then runs OUTPUT_NUM dot
// products through a single time-shared MAC. Each dot product is shifted,
// biased and saturated to int16; the running maximum picks the winning class.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   weight_valid filter carries a weight/bias byte this cycle
//   filter       signed int8 weight or bias byte
//   weight_done  all weights and biases loaded
//   i_valid      data_in valid (accepted only when loaded and idle)
//   data_in      packed signed inputs, input k at [16k+15:16k]
//   busy         computation in progress
//   o_valid      one-cycle pulse, o_class/o_score valid
//   o_class      index of the largest score
//   o_score      saturated score of the winning class
module fc2_argmax #(
   parameter int INPUT_NUM  = 16,
   parameter int OUTPUT_NUM = 10,
   parameter int ACC_W      = 32,
   parameter int SHIFT      = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          weight_valid,
   input  logic [7:0]                    filter,
   output logic                          weight_done,
   input  logic                          i_valid,
   input  logic [16*INPUT_NUM-1:0]       data_in,
   output logic                          busy,
   output logic                          o_valid,
   output logic [$clog2(OUTPUT_NUM)-1:0] o_class,
   output logic [15:0]                   o_score
);

   localparam int NW    = INPUT_NUM * OUTPUT_NUM;
   localparam int NT    = NW + OUTPUT_NUM;
   localparam int CNT_W = $clog2(NT + 1);
   localparam int WA_W  = $clog2(NW);
   localparam int K_W   = $clog2(INPUT_NUM);
   localparam int O_W   = $clog2(OUTPUT_NUM);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_CMP
   } state_t;

   // weight / bias storage and load counter
   logic signed [7:0]        r_wt   [0:NW-1];
   logic signed [7:0]        r_bias [0:OUTPUT_NUM-1];
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_done;

   // datapath / FSM state
   state_t                   r_state;
   logic signed [15:0]       r_x    [0:INPUT_NUM-1];
   logic [K_W-1:0]           r_k;
   logic [O_W-1:0]           r_o;
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [15:0]       r_best;
   logic [O_W-1:0]           r_best_idx;
   logic                     r_busy;
   logic                     r_valid;
   logic [O_W-1:0]           r_class;
   logic signed [15:0]       r_score;

   logic [WA_W-1:0]          w_wa_load;
   logic [O_W-1:0]           w_ba_load;
   logic [WA_W-1:0]          w_widx;
   logic signed [15:0]       w_x;
   logic signed [7:0]        w_w;
   logic signed [23:0]       w_prod;
   logic signed [ACC_W-1:0]  w_prod_ext;
   logic signed [ACC_W-1:0]  w_shift;
   logic signed [ACC_W-1:0]  w_sum;
   logic signed [15:0]       w_score;
   logic                     w_better;
   logic signed [15:0]       w_best_n;
   logic [O_W-1:0]           w_idx_n;

   // Load addresses: beats 0..NW-1 fill the weights, the rest fill biases.
   assign w_wa_load = WA_W'(r_cnt);
   assign w_ba_load = O_W'(r_cnt - CNT_W'(NW));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < NW; i++) r_wt[i] <= '0;
         for (int unsigned i = 0; i < OUTPUT_NUM; i++) r_bias[i] <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (weight_valid && !r_done) begin
         if (r_cnt < CNT_W'(NW)) r_wt[w_wa_load] <= filter;
         else                    r_bias[w_ba_load] <= filter;
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == CNT_W'(NT - 1)) r_done <= 1'b1;
      end
   end

   // MAC operands: 16x8 signed product, sign-extended into the accumulator
   assign w_widx     = WA_W'(r_o) * WA_W'(INPUT_NUM) + WA_W'(r_k);
   assign w_x        = r_x[r_k];
   assign w_w        = r_wt[w_widx];
   assign w_prod     = 24'(w_x) * 24'(w_w);
   assign w_prod_ext = ACC_W'(w_prod);

   // Requantise, bias and saturate to int16
   assign w_shift = r_acc >>> SHIFT;
   assign w_sum   = w_shift + ACC_W'(r_bias[r_o]);

   always_comb begin
      w_score = w_sum[15:0];
      if (w_sum > ACC_W'(32767))       w_score = 16'sd32767;
      else if (w_sum < ACC_W'(-32768)) w_score = -16'sd32768;
   end

   // Strict compare so ties keep the lower class index
   assign w_better = (w_score > r_best);
   assign w_best_n = w_better ? w_score : r_best;
   assign w_idx_n  = w_better ? r_o : r_best_idx;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         for (int unsigned i = 0; i < INPUT_NUM; i++) r_x[i] <= '0;
         r_k        <= '0;
         r_o        <= '0;
         r_acc      <= '0;
         r_best     <= '0;
         r_best_idx <= '0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_class    <= '0;
         r_score    <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_valid && r_done) begin
                  for (int unsigned i = 0; i < INPUT_NUM; i++)
                     r_x[i] <= data_in[16*i +: 16];
                  r_busy     <= 1'b1;
                  r_o        <= '0;
                  r_k        <= '0;
                  r_acc      <= '0;
                  r_best     <= 16'sh8000;
                  r_best_idx <= '0;
                  r_state    <= S_MAC;
               end
            end
            S_MAC: begin
               r_acc <= r_acc + w_prod_ext;
               if (r_k == K_W'(INPUT_NUM - 1)) r_state <= S_CMP;
               else                            r_k     <= r_k + 1'b1;
            end
            S_CMP: begin
               r_best     <= w_best_n;
               r_best_idx <= w_idx_n;
               if (r_o == O_W'(OUTPUT_NUM - 1)) begin
                  // report the updated best, including this last class
                  r_valid <= 1'b1;
                  r_class <= w_idx_n;
                  r_score <= w_best_n;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_o     <= r_o + 1'b1;
                  r_k     <= '0;
                  r_acc   <= '0;
                  r_state <= S_MAC;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign weight_done = r_done;
   assign busy        = r_busy;
   assign o_valid     = r_valid;
   assign o_class     = r_class;
   assign o_score     = r_score;

endmodule

// File: tb/tb_fc2_argmax.sv
// tb_fc2_argmax: self-checking bench for fc2_argmax. A behavioural model
// computes each class score with plain integer arithmetic and picks the
// first maximum; scenario tasks compare DUT results against it.
module tb_fc2_argmax;

   localparam int NI = 16;
   localparam int NO = 10;
   localparam int LAT = NO * (NI + 1);

   logic          clk = 1'b0;
   logic          i_rst;
   logic          weight_valid;
   logic [7:0]    filter;
   logic          weight_done;
   logic          i_valid;
   logic [16*NI-1:0] data_in;
   logic          busy;
   logic          o_valid;
   logic [3:0]    o_class;
   logic [15:0]   o_score;

   int W [NO][NI];
   int B [NO];
   int X [NI];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fc2_argmax #(.INPUT_NUM(NI), .OUTPUT_NUM(NO), .ACC_W(32), .SHIFT(8)) dut (
      .i_clk(clk), .i_rst(i_rst), .weight_valid(weight_valid), .filter(filter),
      .weight_done(weight_done), .i_valid(i_valid), .data_in(data_in),
      .busy(busy), .o_valid(o_valid), .o_class(o_class), .o_score(o_score)
   );

   // ---------------- reference model ----------------
   function automatic void model(output int cls, output int score);
      int best, acc, s;
      best = -32768;
      cls  = 0;
      for (int o = 0; o < NO; o++) begin
         acc = 0;
         for (int k = 0; k < NI; k++) acc += X[k] * W[o][k];
         s = (acc >>> 8) + B[o];
         if (s > 32767) s = 32767;
         if (s < -32768) s = -32768;
         if (s > best) begin best = s; cls = o; end
      end
      score = best;
   endfunction

   function automatic void set_uniform(int w, int b);
      for (int o = 0; o < NO; o++) begin
         B[o] = b;
         for (int k = 0; k < NI; k++) W[o][k] = w;
      end
   endfunction

   function automatic void set_x(int v);
      for (int k = 0; k < NI; k++) X[k] = v;
   endfunction

   function automatic void rand_x(int lim);
      for (int k = 0; k < NI; k++)
         X[k] = int'($urandom_range(2 * lim)) - lim;
   endfunction

   // ---------------- drivers ----------------
   task automatic drive_x();
      for (int k = 0; k < NI; k++) data_in[16*k +: 16] = 16'(X[k]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_rst = 1'b1; weight_valid = 1'b0; i_valid = 1'b0;
      repeat (2) @(negedge clk);
      i_rst = 1'b0;
   endtask

   task automatic load_beats(int first, int last);
      for (int n = first; n <= last; n++) begin
         weight_valid = 1'b1;
         filter = (n < NO * NI) ? 8'(W[n / NI][n % NI]) : 8'(B[n - NO * NI]);
         @(negedge clk);
      end
      weight_valid = 1'b0;
   endtask

   // Starts a computation at the current negedge and waits (bounded) for o_valid.
   task automatic do_run(output int lat, output int cls, output int score, output logic bsy);
      drive_x();
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      bsy = busy;
      lat = -1; cls = -1; score = 0;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (o_valid) begin
            lat = c; cls = int'(o_class); score = int'($signed(o_score));
            break;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int lat, cls, score; logic bsy;
      i_rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (weight_done !== 1'b0) begin n_err++; $display("FAIL reset_weight_done: got %b want 0", weight_done); end
      n_cmp++; if (o_class !== 4'd0) begin n_err++; $display("FAIL reset_o_class: got %0d want 0", o_class); end
      n_cmp++; if (o_score !== 16'd0) begin n_err++; $display("FAIL reset_o_score: got %0d want 0", o_score); end
      i_rst = 1'b0;
      // make outputs non-zero, then reset asynchronously mid-cycle
      set_uniform(1, 0);
      for (int k = 0; k < NI; k++) W[7][k] = 2;
      load_beats(0, NO * NI + NO - 1);
      set_x(256);
      do_run(lat, cls, score, bsy);
      n_cmp++; if (cls !== 7) begin n_err++; $display("FAIL reset_pre_class: got %0d want 7", cls); end
      @(posedge clk); #3;
      i_rst = 1'b1;
      #1;
      n_cmp++; if (o_class !== 4'd0) begin n_err++; $display("FAIL async_o_class: got %0d want 0", o_class); end
      n_cmp++; if (o_score !== 16'd0) begin n_err++; $display("FAIL async_o_score: got %0d want 0", o_score); end
      n_cmp++; if (weight_done !== 1'b0) begin n_err++; $display("FAIL async_weight_done: got %b want 0", weight_done); end
      n_cmp++; if (busy !== 1'b0 || o_valid !== 1'b0) begin n_err++; $display("FAIL async_busy_valid: got %b%b want 00", busy, o_valid); end
      @(negedge clk);
      i_rst = 1'b0;
   endtask

   task automatic test_load_uniform();
      int lat, cls, score; logic bsy;
      do_reset();
      set_uniform(1, 0);
      load_beats(0, NO * NI + NO - 2);
      n_cmp++; if (weight_done !== 1'b0) begin n_err++; $display("FAIL load_done_early: got %b want 0", weight_done); end
      load_beats(NO * NI + NO - 1, NO * NI + NO - 1);
      n_cmp++; if (weight_done !== 1'b1) begin n_err++; $display("FAIL load_done_final: got %b want 1", weight_done); end
      // an extra beat after the final bias must be ignored
      weight_valid = 1'b1; filter = 8'h80;
      @(negedge clk);
      weight_valid = 1'b0;
      set_x(256);
      do_run(lat, cls, score, bsy);
      n_cmp++; if (bsy !== 1'b1) begin n_err++; $display("FAIL uniform_busy: got %b want 1", bsy); end
      n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL uniform_latency: got %0d want %0d", lat, LAT); end
      n_cmp++; if (cls !== 0) begin n_err++; $display("FAIL uniform_class: got %0d want 0", cls); end
      n_cmp++; if (score !== 16) begin n_err++; $display("FAIL uniform_score: got %0d want 16", score); end
      @(negedge clk);
      n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL uniform_pulse_len: got %b want 0", o_valid); end
      n_cmp++; if (o_score !== 16'd16) begin n_err++; $display("FAIL uniform_hold: got %0d want 16", o_score); end
   endtask

   task automatic test_winner();
      int lat, cls, score; logic bsy;
      do_reset();
      set_uniform(1, 0);
      for (int k = 0; k < NI; k++) W[7][k] = 2;
      B[3] = 15;
      load_beats(0, NO * NI + NO - 1);
      set_x(256);
      do_run(lat, cls, score, bsy);
      n_cmp++; if (cls !== 7) begin n_err++; $display("FAIL winner_class: got %0d want 7", cls); end
      n_cmp++; if (score !== 32) begin n_err++; $display("FAIL winner_score: got %0d want 32", score); end
   endtask

   task automatic test_saturation();
      int lat, cls, score; logic bsy;
      do_reset();
      set_uniform(0, 0);
      for (int k = 0; k < NI; k++) W[0][k] = 127;
      B[0] = 127;
      load_beats(0, NO * NI + NO - 1);
      set_x(32767);
      do_run(lat, cls, score, bsy);
      n_cmp++; if (score !== 32767) begin n_err++; $display("FAIL sat_hi_score: got %0d want 32767", score); end
      n_cmp++; if (cls !== 0) begin n_err++; $display("FAIL sat_hi_class: got %0d want 0", cls); end
      do_reset();
      set_uniform(-128, -128);
      load_beats(0, NO * NI + NO - 1);
      do_run(lat, cls, score, bsy);
      n_cmp++; if (score !== -32768) begin n_err++; $display("FAIL sat_lo_score: got %0d want -32768", score); end
      n_cmp++; if (cls !== 0) begin n_err++; $display("FAIL sat_lo_class: got %0d want 0", cls); end
   endtask

   task automatic test_gating();
      int ecls, escore, pulses, first, gcls, gscore, nbusy;
      do_reset();
      // i_valid before weights are loaded
      rand_x(30000); drive_x();
      i_valid = 1'b1;
      repeat (3) @(negedge clk);
      i_valid = 1'b0;
      pulses = 0; nbusy = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (o_valid) pulses++;
         if (busy) nbusy++;
      end
      n_cmp++; if (pulses !== 0 || nbusy !== 0) begin n_err++; $display("FAIL gate_unloaded: got pulses=%0d busy=%0d want 0/0", pulses, nbusy); end
      // random weights, i_valid pulses while busy (including the final CMP edge)
      for (int o = 0; o < NO; o++) begin
         B[o] = int'($urandom_range(255)) - 128;
         for (int k = 0; k < NI; k++) W[o][k] = int'($urandom_range(255)) - 128;
      end
      load_beats(0, NO * NI + NO - 1);
      rand_x(4000);
      model(ecls, escore);
      drive_x();
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      pulses = 0; first = -1; nbusy = 0; gcls = -1; gscore = 0;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (busy && c < LAT) nbusy++;
         if (o_valid) begin
            pulses++;
            if (first < 0) begin first = c; gcls = int'(o_class); gscore = int'($signed(o_score)); end
         end
         if (c == 10 || c == 60 || c == LAT - 1) begin
            rand_x(30000); drive_x(); i_valid = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
      end
      n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL gate_busy_pulses: got %0d want 1", pulses); end
      n_cmp++; if (first !== LAT) begin n_err++; $display("FAIL gate_busy_latency: got %0d want %0d", first, LAT); end
      n_cmp++; if (nbusy !== LAT - 1) begin n_err++; $display("FAIL gate_busy_level: got %0d want %0d", nbusy, LAT - 1); end
      n_cmp++; if (gcls !== ecls || gscore !== escore) begin n_err++; $display("FAIL gate_busy_result: got %0d/%0d want %0d/%0d", gcls, gscore, ecls, escore); end
   endtask

   task automatic test_back_to_back();
      int lat, cls, score, ecls, escore; logic bsy;
      rand_x(3000); model(ecls, escore);
      do_run(lat, cls, score, bsy);
      n_cmp++; if (cls !== ecls || score !== escore) begin n_err++; $display("FAIL b2b_first: got %0d/%0d want %0d/%0d", cls, score, ecls, escore); end
      // accept the next input in the o_valid cycle
      rand_x(3000); model(ecls, escore);
      do_run(lat, cls, score, bsy);
      n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
      n_cmp++; if (cls !== ecls || score !== escore) begin n_err++; $display("FAIL b2b_second: got %0d/%0d want %0d/%0d", cls, score, ecls, escore); end
   endtask

   task automatic test_abort();
      int lat, cls, score, pulses, nbusy; logic bsy;
      rand_x(3000); drive_x();
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      repeat (49) @(negedge clk);
      @(posedge clk); #2;
      i_rst = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0 || weight_done !== 1'b0) begin n_err++; $display("FAIL abort_state: got busy=%b done=%b want 0/0", busy, weight_done); end
      @(negedge clk);
      i_rst = 1'b0;
      pulses = 0; nbusy = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (o_valid) pulses++;
         if (busy) nbusy++;
      end
      n_cmp++; if (pulses !== 0 || nbusy !== 0) begin n_err++; $display("FAIL abort_quiet: got pulses=%0d busy=%0d want 0/0", pulses, nbusy); end
      set_uniform(1, 0);
      load_beats(0, NO * NI + NO - 1);
      set_x(256);
      do_run(lat, cls, score, bsy);
      n_cmp++; if (lat !== LAT || cls !== 0 || score !== 16) begin n_err++; $display("FAIL abort_reload: got lat=%0d %0d/%0d want %0d 0/16", lat, cls, score, LAT); end
   endtask

   task automatic test_random();
      int lat, cls, score, ecls, escore; logic bsy;
      do_reset();
      for (int o = 0; o < NO; o++) begin
         B[o] = int'($urandom_range(255)) - 128;
         for (int k = 0; k < NI; k++) W[o][k] = int'($urandom_range(255)) - 128;
      end
      load_beats(0, NO * NI + NO - 1);
      for (int r = 0; r < 6; r++) begin
         rand_x((r % 2 == 0) ? 2000 : 32767);
         model(ecls, escore);
         do_run(lat, cls, score, bsy);
         n_cmp++; if (lat !== LAT || cls !== ecls || score !== escore) begin
            n_err++;
            $display("FAIL random_%0d: got lat=%0d %0d/%0d want %0d %0d/%0d", r, lat, cls, score, LAT, ecls, escore);
         end
      end
   endtask

   initial begin
      i_rst = 1'b0; weight_valid = 1'b0; filter = '0; i_valid = 1'b0; data_in = '0;
      #1;
      test_reset();
      test_load_uniform();
      test_winner();
      test_saturation();
      test_gating();
      test_back_to_back();
      test_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
